// File: rtl/mips_regfile.sv
// 32-entry MIPS general-purpose register file: two combinational read ports,
// one write port, hardwired $0, programmable $sp reset value and a saturating write counter.
module mips_regfile #(
  parameter int unsigned WIDTH               = 32,
  parameter int unsigned ADDR_W              = 5,
  parameter bit          BYPASS              = 1'b1,
  parameter int unsigned SP_IDX              = 29,
  parameter logic [WIDTH-1:0] SP_RESET       = WIDTH'(32'h0000_7FFC)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we3,
  input  logic [ADDR_W-1:0] wa3,
  input  logic [WIDTH-1:0]  wd3,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [WIDTH-1:0]  rd1,
  output logic [WIDTH-1:0]  rd2,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [WIDTH-1:0]  dbg_data,
  output logic [15:0]       wr_count
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = 16;

  logic [WIDTH-1:0] regs [DEPTH];
  logic             commit_c;
  logic             fwd_ok_c;

  // Writes to $0 are dropped and never counted.
  assign commit_c = we3 && (wa3 != '0);
  // Forwarding is suppressed while reset is held so reads show stored contents.
  assign fwd_ok_c = BYPASS && rst_n && we3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs[ADDR_W'(i)] <= (i == SP_IDX) ? SP_RESET : '0;
      end
      wr_count <= '0;
    end else if (commit_c) begin
      regs[wa3] <= wd3;
      if (wr_count != {CNT_W{1'b1}}) begin
        wr_count <= wr_count + CNT_W'(1);
      end
    end
  end

  // Read port 1 (rs): zero for $0, write-through when forwarding matches.
  always_comb begin
    rd1 = '0;
    if (ra1 != '0) begin
      if (fwd_ok_c && (wa3 == ra1)) rd1 = wd3;
      else                          rd1 = regs[ra1];
    end
  end

  // Read port 2 (rt).
  always_comb begin
    rd2 = '0;
    if (ra2 != '0) begin
      if (fwd_ok_c && (wa3 == ra2)) rd2 = wd3;
      else                          rd2 = regs[ra2];
    end
  end

  // Debug port never forwards; it always shows committed state.
  always_comb begin
    dbg_data = '0;
    if (dbg_addr != '0) dbg_data = regs[dbg_addr];
  end

endmodule

// File: tb/tb_mips_regfile.sv
// Scoreboard bench for mips_regfile: forwarding and non-forwarding instances share
// stimulus; expected values are queued at drive time and popped at the sample point.
module tb_mips_regfile;

  logic        clk = 1'b0;
  logic        rst_n, we3;
  logic [4:0]  wa3, ra1, ra2, dbg_addr;
  logic [31:0] wd3;
  logic [31:0] b_rd1, b_rd2, b_dbg, n_rd1, n_rd2, n_dbg;
  logic [15:0] b_wrc, n_wrc;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] model [32];
  logic [15:0] cnt_model;
  logic [31:0] sb [$];

  always #5 clk = ~clk;

  mips_regfile #(.BYPASS(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .we3(we3), .wa3(wa3), .wd3(wd3),
    .ra1(ra1), .ra2(ra2), .rd1(b_rd1), .rd2(b_rd2),
    .dbg_addr(dbg_addr), .dbg_data(b_dbg), .wr_count(b_wrc)
  );

  mips_regfile #(.BYPASS(1'b0)) dut_n (
    .clk(clk), .rst_n(rst_n), .we3(we3), .wa3(wa3), .wd3(wd3),
    .ra1(ra1), .ra2(ra2), .rd1(n_rd1), .rd2(n_rd2),
    .dbg_addr(dbg_addr), .dbg_data(n_dbg), .wr_count(n_wrc)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) model[i] = (i == 29) ? 32'h0000_7FFC : 32'h0;
    cnt_model = 16'h0;
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] ra, input bit byp);
    if (ra == 5'd0) return 32'h0;
    if (byp && rst_n && we3 && (wa3 == ra)) return wd3;
    return model[ra];
  endfunction

  // Called just after a rising edge: drive, queue expectations, check at negedge, update model.
  task automatic step(input logic w, input logic [4:0] a, input logic [31:0] d,
                      input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] dba);
    we3 = w; wa3 = a; wd3 = d; ra1 = r1; ra2 = r2; dbg_addr = dba;
    sb.push_back(exp_rd(r1, 1'b1));
    sb.push_back(exp_rd(r2, 1'b1));
    sb.push_back(exp_rd(r1, 1'b0));
    sb.push_back(exp_rd(r2, 1'b0));
    sb.push_back((dba == 5'd0) ? 32'h0 : model[dba]);
    sb.push_back({16'h0, cnt_model});
    sb.push_back({16'h0, cnt_model});
    @(negedge clk);
    check("byp_rd1",  b_rd1,          sb.pop_front());
    check("byp_rd2",  b_rd2,          sb.pop_front());
    check("nob_rd1",  n_rd1,          sb.pop_front());
    check("nob_rd2",  n_rd2,          sb.pop_front());
    check("dbg_data", b_dbg,          sb.pop_front());
    check("byp_wrc",  {16'h0, b_wrc}, sb.pop_front());
    check("nob_wrc",  {16'h0, n_wrc}, sb.pop_front());
    @(posedge clk);
    if (!rst_n) model_reset();
    else if (w && a != 5'd0) begin
      model[a] = d;
      if (cnt_model != 16'hFFFF) cnt_model = cnt_model + 16'd1;
    end
    #1;
  endtask

  initial begin
    int extra;
    rst_n = 1'b1; we3 = 1'b0; wa3 = '0; wd3 = '0; ra1 = '0; ra2 = '0; dbg_addr = '0;
    model_reset();
    #2 rst_n = 1'b0;
    @(posedge clk); #1;

    // Reset contents on every address; writes ignored and forwarding suppressed.
    for (int i = 0; i < 32; i++)
      step(1'b1, 5'(i), 32'hA5A5_0000 | 32'(i), 5'(i), 5'(31 - i), 5'(i));
    rst_n = 1'b1;

    // Plain write then read back.
    step(1'b1, 5'd8, 32'hDEAD_BEEF, 5'd8, 5'd29, 5'd8);
    step(1'b0, 5'd0, 32'h0, 5'd8, 5'd8, 5'd8);

    // $0 write is discarded, same cycle and after.
    step(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0);
    step(1'b0, 5'd0, 32'h0, 5'd0, 5'd8, 5'd0);

    // Same-cycle write/read of one address: forwarding differs between instances.
    step(1'b1, 5'd9, 32'h1, 5'd1, 5'd2, 5'd9);
    step(1'b1, 5'd9, 32'h5, 5'd9, 5'd9, 5'd9);
    step(1'b0, 5'd0, 32'h0, 5'd9, 5'd9, 5'd9);

    // Reset pulse between edges kills the pending write.
    step(1'b1, 5'd10, 32'h7, 5'd10, 5'd10, 5'd10);
    we3 = 1'b1; wa3 = 5'd10; wd3 = 32'h9; ra1 = 5'd10; ra2 = 5'd10; dbg_addr = 5'd10;
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    sb.push_back(32'h0); sb.push_back(32'h0); sb.push_back({16'h0, cnt_model});
    check("rstmid_rd1", b_rd1,          sb.pop_front());
    check("rstmid_rd2", n_rd2,          sb.pop_front());
    check("rstmid_wrc", {16'h0, b_wrc}, sb.pop_front());
    we3 = 1'b0;
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    step(1'b0, 5'd0, 32'h0, 5'd10, 5'd29, 5'd10);

    // Random traffic until the write counter saturates, plus a few cycles past it.
    extra = 0;
    for (int i = 0; i < 80000 && extra < 6; i++) begin
      logic [4:0] a, r1;
      a  = 5'($urandom_range(0, 31));
      r1 = ($urandom_range(0, 7) == 0) ? a : 5'($urandom_range(0, 31));
      step(1'b1, a, $urandom, r1, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      if (cnt_model == 16'hFFFF) extra++;
    end
    @(negedge clk);
    check("wrc_saturated", {16'h0, b_wrc}, 32'h0000_FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
